// File: rtl/esp_uart_pkg.sv
// Shared definitions for the ESP32 UART transmit and receive paths.
package esp_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Level on CTS/RTS meaning "peer not ready"; the RX side drives RTS with the same sense.
  localparam logic CTS_HOLD_OFF = 1'b1;

endpackage

// File: rtl/esp_uart_txfifo.sv
// First-word-fall-through synchronous FIFO; same structure as the receive-side FIFO.
module esp_uart_txfifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rddata,
  input  logic              rd_en,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                wr_ok;
  logic                rd_ok;

  // Extra pointer bit separates full (lap differs) from empty (same lap).
  assign full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign rddata = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wrdata;
  end

endmodule

// File: rtl/esp_uart_txq.sv
// Buffered 8N1 UART transmitter to the ESP32 with CTS flow control checked before each frame.
module esp_uart_txq
  import esp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 14,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       tx_idle,
  output logic       uart_txd,
  input  logic       uart_cts
);

  localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e   state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift, shift_d;
  logic        txd_d;
  logic        pop;
  logic [7:0]  fifo_rdata;
  logic        cts_meta, cts_sync;
  logic        cts_ok;
  logic        start_ok;
  logic        bit_done;

  esp_uart_txfifo #(
    .DATA_W     (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrdata (wr_data),
    .wr_en  (wr_en),
    .rddata (fifo_rdata),
    .rd_en  (pop),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // CTS synchronizer comes out of reset holding the link off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta <= CTS_HOLD_OFF;
      cts_sync <= CTS_HOLD_OFF;
    end else begin
      cts_meta <= uart_cts;
      cts_sync <= cts_meta;
    end
  end

  assign cts_ok   = (cts_sync != CTS_HOLD_OFF);
  assign start_ok = !fifo_empty && cts_ok;
  assign bit_done = (cnt == CNT_MAX);
  assign tx_idle  = fifo_empty && (state == ST_IDLE);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 16'd1;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    txd_d     = uart_txd;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          txd_d     = shift[0];
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx == BIT_LAST) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = {1'b0, shift[7:1]};
            txd_d     = shift[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (start_ok) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            txd_d   = 1'b0;
            state_d = ST_START;
          end else begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      uart_txd <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      uart_txd <= txd_d;
      overflow <= wr_en && fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_d;
  end

endmodule

// File: doc/esp_uart_txq.md
Name: esp_uart_txq

Overview:
Buffered, flow-controlled UART transmitter toward the ESP32; the transmit-side counterpart of the buffered receive path.
- Host side pushes bytes into a TX FIFO.
- A serializer drains the FIFO as 8N1 frames on uart_txd.
- Before each frame it honours the ESP's uart_cts: high = ESP not ready, the same polarity our RTS drives.
- Removes busy-polling of the bare transmitter from host software.

Parameters:
CLKS_PER_BIT, 14, clk cycles per UART bit; legal range 2..65535.
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 entries (16).

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  reset, asynchronous, active-low.
wr_data  in  8  byte to queue.
wr_en  in  1  push wr_data into the FIFO this cycle.
fifo_full  out  1  FIFO holds 2**FIFO_DEPTH_LOG2 entries.
fifo_empty  out  1  FIFO holds 0 entries.
overflow  out  1  one-cycle pulse: wr_en was seen while fifo_full, byte dropped.
tx_idle  out  1  FIFO empty and serializer in IDLE.
uart_txd  out  1  serial output, idle high, registered.
uart_cts  in  1  ESP flow control, asynchronous; 1 = hold off.

Behaviour:
Reset (rst_n low, effective immediately):
- uart_txd=1, fifo_empty=1, fifo_full=0, overflow=0, tx_idle=1.
- FIFO pointers cleared; any in-flight frame is abandoned (line returns high at once).
- CTS synchronizer flops reset to 1 (hold off).

FIFO:
- Synchronous, first-word-fall-through to the serializer.
- A write is accepted when wr_en=1 and fifo_full=0, judged on pre-edge state.
- Write while full: byte dropped, overflow=1 for the next cycle. This applies even if a pop occurs the same edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged.
- Pointers are FIFO_DEPTH_LOG2+1 bits; wrap is modulo 2**(FIFO_DEPTH_LOG2+1).
- full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.

CTS:
- 2-flop synchronizer; cts_ok = !cts_sync.
- Sampled only when deciding to start a frame. Deasserting CTS mid-frame never truncates the frame.

FSM states IDLE, START, DATA, STOP:
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1. bit_idx: 3 bits.
- IDLE: if !fifo_empty and cts_ok, pop the byte into the shift register, set txd<=0, counter=0, and go to START.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: txd=shift[0], LSB first, each bit CLKS_PER_BIT cycles. After bit 7 go to STOP with txd<=1.
- STOP: txd=1 for CLKS_PER_BIT cycles. On the last stop cycle:
  - if !fifo_empty and cts_ok, pop and go straight to START (back-to-back, no gap);
  - otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have zero idle cycles between them.

Latency:
- Setup: FIFO empty, FSM in IDLE, cts_ok already true, wr_en at edge k.
- uart_txd falls after edge k+1, i.e. 2 cycles.
- CTS falling edge to frame start: at most 3 cycles (2 synchronizer stages + the start decision).

tx_idle:
- Equals fifo_empty AND state==IDLE, registered-consistent with both.
- Goes high on the cycle after the final stop bit completes.

Decomposition:
- Package esp_uart_pkg holds:
  - FSM state enum;
  - FRAME_BITS=10 and DATA_BITS=8 constants;
  - the CTS-hold-off polarity constant, shared with the RX/RTS side.
- One sub-module: esp_uart_txfifo, a parameterized sync FIFO with wrdata/wr_en/rddata/rd_en/empty/full. It is structurally mirrored on the receive FIFO.
- Serializer, baud counter and CTS synchronizer stay in esp_uart_txq.

Test Plan:
- CLKS_PER_BIT=4, cts=0, write 0xA5 once -> txd low at cycle k+2; bits 1,0,1,0,0,1,0,1 every 4 cycles; stop high; tx_idle=1 exactly 40 cycles after txd fell.
- Write 0x00,0xFF,0x55 in consecutive cycles, cts=0 -> three frames, 120 contiguous cycles, no idle gap between stop and next start; decoded bytes match in order.
- Hold cts=1, write 17 bytes with depth 16 -> txd stays 1; fifo_full after 16th write; 17th write gives one overflow pulse. Release cts -> first start bit within 3 cycles; 16 bytes sent in order.
- Raise cts mid-frame on the 2nd of 3 queued bytes -> 2nd frame completes fully; 3rd not started until cts=0.
- Assert rst_n=0 during a DATA bit of frame 1 with 4 bytes queued -> txd=1 immediately; fifo_empty=1. After release with cts=0, no frame is sent until a new write.
- Fill FIFO to full while draining with cts=0, wrapping pointers ≥3 times (≥50 bytes) -> all bytes received in order, no spurious full/empty.
